roll_sequencer: RTL and testbench
=================================

# roll_sequencer

Controller that sequences the dice-roll BCD countdown datapath. It latches the chosen die type, spins the counter one step per clock while a button is held, then runs a decelerating settle phase on the 32 Hz tick before freezing the result. It sits between the debounced button bank / prescaler tick and the two-digit BCD counter feeding the seven-segment multiplexer.

## Interface
- SETTLE_STEPS, default 6: number of decelerating steps after button release; legal range 1–15.
- clk  in  1  system clock, 32768 Hz.
- rst_n  in  1  reset, synchronous, active-low.
- tick  in  1  one-cycle pulse at 32 Hz from the prescaler.
- btn_any  in  1  OR of all debounced die buttons.
- die_sel  in  3  die code of the pressed button, sampled only on roll start: 0=d4, 1=d6, 2=d8, 3=d10, 4=d12, 5=d20, 6=d100, 7=none.
- cnt_is_one  in  1  datapath counter currently holds BCD 01.
- step  out  1  decrement strobe to the BCD counter.
- load  out  1  load strobe; counter takes load_val.
- load_val  out  8  BCD load value for the latched die.
- blank  out  1  display blank request.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the result is final.

## Operation
- States: IDLE, ROLL, SETTLE. Internal regs: die_reg (3b, 7=none), k (settle step count, 4b), ic (tick interval count, 4b).
- load_val mapping from die_reg: d4→0x04, d6→0x06, d8→0x08, d10→0x10, d12→0x12, d20→0x20, d100→0x00 (00 means 100); none→0x00.
- Wrap rule: every step opportunity issues load if cnt_is_one=1, else step. load and step never assert together.
- IDLE: btn_any=1 and die_sel≠7 → die_reg←die_sel, issue load, go ROLL. btn_any=1, die_sel=7, die_reg≠7 → keep die_reg, issue load, go ROLL. btn_any=1, die_sel=7, die_reg=7 → stay IDLE, no strobe.
- ROLL: btn_any=1 → step opportunity every cycle. btn_any=0 → go SETTLE, k←0, ic←0, no strobe.
- SETTLE: on each tick, ic←ic+1. When a tick brings ic to k+1 → step opportunity, k←k+1, ic←0. When that makes k=SETTLE_STEPS → go IDLE and pulse done. btn_any=1 in SETTLE → go ROLL, no reload, die_reg unchanged.
- blank=1 in ROLL only; 0 in IDLE and SETTLE, so deceleration is visible.
- Reset: state IDLE, die_reg=7, k=0, ic=0; step, load, blank, busy, done all 0; load_val=0x00. Reset mid-roll aborts without done.

## Timing
- All outputs are registered. Each strobe asserts for exactly one cycle, in the cycle after the edge that caused it.
- Roll start: btn_any=1 sampled at edge N in IDLE → load=1, busy=1, blank=1 during cycle N+1.
- ROLL: one step or load per cycle, back-to-back, while btn_any stays high.
- Release: btn_any=0 at edge M → blank=0 in cycle M+1, no strobe.
- Settle intervals are 1, 2, …, SETTLE_STEPS ticks, for a total of SETTLE_STEPS·(SETTLE_STEPS+1)/2 ticks (21 ticks, about 0.66 s, at the default).
- done=1 and busy=0 in the same cycle as the final step strobe.
- A tick arriving in the same cycle as btn_any rising in SETTLE is ignored. ROLL takes priority.

## Structure
- Package roll_pkg holds:
  - the die code constants (D4..D100, DIE_NONE=7);
  - the state enum (IDLE, ROLL, SETTLE);
  - a function die_to_bcd(die) returning the 8-bit load value.
- Sub-module settle_timer holds the k/ic counters. It takes tick, clear and enable, and outputs fire and last.
- The top is the FSM plus strobe registers.

## Test plan
- Reset, then btn_any=1 with die_sel=1 for 1 cycle → load=1 with load_val=0x06 the next cycle; then SETTLE.
- Hold btn_any 10 cycles with cnt_is_one=0 → load, then 9 consecutive step pulses, blank=1 throughout; release → blank=0.
- cnt_is_one=1 during ROLL → load (0x20 for d20) instead of step, in the same slot.
- SETTLE_STEPS=6, release, ticks every 4 cycles → steps after ticks 1, 3, 6, 10, 15, 21; done pulse coincides with the 6th step; busy=0 afterwards.
- Press during SETTLE after 2 steps → back to ROLL, no load, die_reg kept; release → settle restarts from k=0.
- After reset, btn_any=1 with die_sel=7 → no strobe, state stays IDLE. rst_n=0 mid-SETTLE → all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/roll_pkg.sv
// rtl/roll_pkg.sv - die codes, sequencer states and die-to-BCD load value mapping
package roll_pkg;

    localparam logic [2:0] D4       = 3'd0;
    localparam logic [2:0] D6       = 3'd1;
    localparam logic [2:0] D8       = 3'd2;
    localparam logic [2:0] D10      = 3'd3;
    localparam logic [2:0] D12      = 3'd4;
    localparam logic [2:0] D20      = 3'd5;
    localparam logic [2:0] D100     = 3'd6;
    localparam logic [2:0] DIE_NONE = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROLL   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // d100 loads 00, which the two-digit counter displays as 100
    function automatic logic [7:0] die_to_bcd(input logic [2:0] die);
        logic [7:0] val;
        case (die)
            D4:      val = 8'h04;
            D6:      val = 8'h06;
            D8:      val = 8'h08;
            D10:     val = 8'h10;
            D12:     val = 8'h12;
            D20:     val = 8'h20;
            D100:    val = 8'h00;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - decelerating step timer: step k fires after k+1 ticks
module settle_timer #(
    parameter int SETTLE_STEPS = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clear,
    input  logic enable,
    output logic fire,
    output logic last
);

    logic [3:0] k;
    logic [3:0] ic;

    // a tick that would bring ic to k+1 is the step opportunity
    assign fire = enable && tick && (ic == k);
    assign last = fire && (k == 4'(SETTLE_STEPS - 1));

    // count ticks within the current interval and completed intervals
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            k  <= 4'd0;
            ic <= 4'd0;
        end else if (enable && tick) begin
            if (fire) begin
                k  <= k + 4'd1;
                ic <= 4'd0;
            end else begin
                ic <= ic + 4'd1;
            end
        end
    end

endmodule

// File: rtl/roll_sequencer.sv
// rtl/roll_sequencer.sv - dice-roll FSM driving the BCD countdown counter strobes
module roll_sequencer
    import roll_pkg::*;
#(
    parameter int SETTLE_STEPS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_any,
    input  logic [2:0] die_sel,
    input  logic       cnt_is_one,
    output logic       step,
    output logic       load,
    output logic [7:0] load_val,
    output logic       blank,
    output logic       busy,
    output logic       done
);

    state_t     state;
    logic [2:0] die_reg;
    logic       timer_clear;
    logic       timer_enable;
    logic       fire;
    logic       last;

    // counters restart on every release; a press in SETTLE masks the tick
    assign timer_clear  = (state == ROLL) && !btn_any;
    assign timer_enable = (state == SETTLE) && !btn_any;

    settle_timer #(
        .SETTLE_STEPS(SETTLE_STEPS)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .clear (timer_clear),
        .enable(timer_enable),
        .fire  (fire),
        .last  (last)
    );

    // state transitions with registered one-cycle strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            die_reg  <= DIE_NONE;
            step     <= 1'b0;
            load     <= 1'b0;
            load_val <= 8'h00;
            blank    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            step <= 1'b0;
            load <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_any && die_sel != DIE_NONE) begin
                        die_reg  <= die_sel;
                        load_val <= die_to_bcd(die_sel);
                        load     <= 1'b1;
                        blank    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ROLL;
                    end else if (btn_any && die_reg != DIE_NONE) begin
                        load_val <= die_to_bcd(die_reg);
                        load     <= 1'b1;
                        blank    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ROLL;
                    end
                end
                ROLL: begin
                    if (btn_any) begin
                        load <= cnt_is_one;
                        step <= !cnt_is_one;
                    end else begin
                        blank <= 1'b0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (btn_any) begin
                        blank <= 1'b1;
                        state <= ROLL;
                    end else if (fire) begin
                        load <= cnt_is_one;
                        step <= !cnt_is_one;
                        if (last) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    blank <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_roll_sequencer.sv
// tb/tb_roll_sequencer.sv - self-checking bench for roll_sequencer
module tb_roll_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       btn_any;
    logic [2:0] die_sel;
    logic       cnt_is_one;
    logic       step;
    logic       load;
    logic [7:0] load_val;
    logic       blank;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    roll_sequencer #(.SETTLE_STEPS(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .btn_any   (btn_any),
        .die_sel   (die_sel),
        .cnt_is_one(cnt_is_one),
        .step      (step),
        .load      (load),
        .load_val  (load_val),
        .blank     (blank),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic       r;
        logic       b;
        logic [2:0] s;
        logic       o;
        logic       t;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [12:0] pk(input logic st, input logic ld, input logic [7:0] lv,
                                       input logic bl, input logic bs, input logic dn);
        return {st, ld, lv, bl, bs, dn};
    endfunction

    function automatic logic [12:0] outv();
        return {step, load, load_val, blank, busy, done};
    endfunction

    task automatic add(input logic r, input logic b, input logic [2:0] s, input logic o,
                       input logic t, input logic [12:0] e);
        vec_t v;
        v.r = r; v.b = b; v.s = s; v.o = o; v.t = t; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic cyc(input logic r, input logic b, input logic [2:0] s, input logic o,
                       input logic t);
        rst_n = r; btn_any = b; die_sel = s; cnt_is_one = o; tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int exp_ticks[6] = '{1, 3, 6, 10, 15, 21};
        int step_ticks[$];
        int steps_seen;
        int spurious;
        int done_tick;
        logic done_step;
        logic done_busy;
        string nm;

        rst_n = 1'b0; btn_any = 1'b0; die_sel = 3'd7; cnt_is_one = 1'b0; tick = 1'b0;

        //   r  b  sel o  t   step ld lv     bl bs dn
        add(0, 0, 7, 0, 0, pk(0, 0, 8'h00, 0, 0, 0));  // reset state
        add(1, 1, 7, 0, 0, pk(0, 0, 8'h00, 0, 0, 0));  // none with no prior die
        add(1, 0, 7, 0, 0, pk(0, 0, 8'h00, 0, 0, 0));
        add(1, 1, 1, 0, 0, pk(0, 1, 8'h06, 1, 1, 0));  // d6 roll start
        add(1, 0, 1, 0, 0, pk(0, 0, 8'h06, 0, 1, 0));  // release into SETTLE
        add(1, 1, 5, 0, 0, pk(0, 0, 8'h06, 1, 1, 0));  // press in SETTLE, no reload
        add(1, 1, 5, 0, 0, pk(1, 0, 8'h06, 1, 1, 0));  // die kept, steps
        add(1, 1, 5, 1, 0, pk(0, 1, 8'h06, 1, 1, 0));  // wrap load
        add(1, 0, 5, 0, 0, pk(0, 0, 8'h06, 0, 1, 0));  // release
        add(1, 0, 5, 0, 1, pk(1, 0, 8'h06, 0, 1, 0));  // tick 1 -> step k=0
        add(1, 0, 5, 0, 1, pk(0, 0, 8'h06, 0, 1, 0));
        add(1, 0, 5, 0, 1, pk(1, 0, 8'h06, 0, 1, 0));  // 2nd step
        add(1, 1, 5, 0, 1, pk(0, 0, 8'h06, 1, 1, 0));  // press wins over tick
        add(1, 0, 5, 0, 0, pk(0, 0, 8'h06, 0, 1, 0));  // release, k restarts
        add(1, 0, 5, 0, 1, pk(1, 0, 8'h06, 0, 1, 0));  // first interval is 1 tick again
        add(0, 0, 5, 0, 0, pk(0, 0, 8'h00, 0, 0, 0));  // reset
        add(1, 1, 7, 0, 0, pk(0, 0, 8'h00, 0, 0, 0));  // die_reg cleared by reset
        add(1, 1, 5, 0, 0, pk(0, 1, 8'h20, 1, 1, 0));  // d20 start
        add(1, 1, 5, 1, 0, pk(0, 1, 8'h20, 1, 1, 0));  // wrap load 0x20
        add(1, 1, 5, 0, 0, pk(1, 0, 8'h20, 1, 1, 0));
        add(1, 0, 5, 0, 0, pk(0, 0, 8'h20, 0, 1, 0));
        add(1, 0, 7, 0, 0, pk(0, 0, 8'h20, 0, 1, 0));  // SETTLE, no tick
        add(0, 0, 7, 0, 0, pk(0, 0, 8'h00, 0, 0, 0));
        add(1, 1, 6, 0, 0, pk(0, 1, 8'h00, 1, 1, 0));  // d100 loads 00

        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].b, vecs[i].s, vecs[i].o, vecs[i].t);
            nm = $sformatf("vec%0d", i);
            chk(nm, 32'(outv()), 32'(vecs[i].exp));
        end

        // long hold, release, full settle with ticks every 4 cycles
        cyc(0, 0, 7, 0, 0);
        cyc(1, 1, 3, 0, 0);
        chk("hold_start", 32'(outv()), 32'(pk(0, 1, 8'h10, 1, 1, 0)));
        steps_seen = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1, 1, 3, 0, 0);
            if (outv() == pk(1, 0, 8'h10, 1, 1, 0)) steps_seen++;
        end
        chk("hold_steps", 32'(steps_seen), 32'd9);
        cyc(1, 0, 3, 0, 0);
        chk("release", 32'(outv()), 32'(pk(0, 0, 8'h10, 0, 1, 0)));

        spurious = 0;
        done_tick = -1;
        done_step = 1'b0;
        done_busy = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            cyc(1, 0, 3, 0, 1);
            if (step || load) step_ticks.push_back(t);
            if (done) begin
                done_tick = t;
                done_step = step;
                done_busy = busy;
                break;
            end
            for (int j = 0; j < 3; j++) begin
                cyc(1, 0, 3, 0, 0);
                if (step || load || done) spurious++;
            end
        end
        chk("settle_step_count", 32'(step_ticks.size()), 32'd6);
        for (int i = 0; i < 6 && i < step_ticks.size(); i++) begin
            nm = $sformatf("settle_step%0d_tick", i + 1);
            chk(nm, 32'(step_ticks[i]), 32'(exp_ticks[i]));
        end
        chk("settle_spurious", 32'(spurious), 32'd0);
        chk("done_tick", 32'(done_tick), 32'd21);
        chk("done_with_step", 32'(done_step), 32'd1);
        chk("done_busy", 32'(done_busy), 32'd0);
        cyc(1, 0, 3, 0, 1);
        chk("after_done", 32'(outv()), 32'(pk(0, 0, 8'h10, 0, 0, 0)));

        // reset mid-SETTLE on a tick that would have stepped
        cyc(1, 1, 2, 0, 0);
        chk("b_start", 32'(outv()), 32'(pk(0, 1, 8'h08, 1, 1, 0)));
        cyc(1, 0, 2, 0, 0);
        cyc(1, 0, 2, 0, 1);
        chk("b_step1", 32'(outv()), 32'(pk(1, 0, 8'h08, 0, 1, 0)));
        cyc(1, 0, 2, 0, 1);
        cyc(0, 0, 2, 0, 1);
        chk("b_reset", 32'(outv()), 32'(pk(0, 0, 8'h00, 0, 0, 0)));
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 7, 0, 1);
            nm = $sformatf("b_idle%0d", i);
            chk(nm, 32'(outv()), 32'(pk(0, 0, 8'h00, 0, 0, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
